// File: rtl/shift_register_pkg.sv
// Shared types and elaboration helpers for the shift_register_serdes engine.
`timescale 1ns/1ps
package shift_register_pkg;

    // Engine states: idle/accepting, shifting beats, holding the captured word.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Number of beats needed to move one word through the lanes.
    function automatic int nbeats(input int width, input int lanes);
        return width / lanes;
    endfunction

    // Counter width for n states; a single-beat engine still needs one bit.
    function automatic int cnt_w(input int n);
        return (n <= 32'sd1) ? 32'sd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_register_serdes_beat_counter.sv
// Beat counter for the shift engine: counts 0..N-1, never wraps past N-1.
`timescale 1ns/1ps
module shift_beat_counter
    import shift_register_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [cnt_w(N)-1:0]   count,
    output logic                  last
);

    localparam int              CW       = cnt_w(N);
    localparam logic [CW-1:0]   LAST_VAL = CW'(N - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, increment saturates at the last beat.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LAST_VAL)) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == LAST_VAL);

endmodule

// File: rtl/shift_register_serdes.sv
// Full-duplex parallel/serial shift engine: loads a word, shifts it out LANES
// bits per shift_en beat while capturing ser_in, then presents the capture.
`timescale 1ns/1ps
module shift_register_serdes
    import shift_register_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              load_msb_first,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic              shift_en,
    input  logic              abort,
    input  logic [LANES-1:0]  ser_in,
    output logic [LANES-1:0]  ser_out,
    output logic              busy,
    output logic [WIDTH-1:0]  cap_data,
    output logic              cap_valid,
    input  logic              cap_ready
);

    localparam int NB = nbeats(WIDTH, LANES);
    localparam int CW = cnt_w(NB);

    if (((WIDTH % LANES) != 0) || (LANES > WIDTH)) begin : g_param_err
        $error("shift_register_serdes: WIDTH must be a non-zero multiple of LANES");
    end

    state_t            state_q;
    state_t            state_d;
    logic [WIDTH-1:0]  sreg_q;
    logic [WIDTH-1:0]  sreg_d;
    logic              msb_first_q;
    logic              msb_first_d;
    logic              cnt_clr_s;
    logic              cnt_inc_s;
    logic              cnt_last_s;
    logic [CW-1:0]     beat_cnt_s;
    logic [WIDTH-1:0]  shl_s;
    logic [WIDTH-1:0]  shr_s;

    // When one beat moves the whole word there is no remaining slice to keep.
    if (LANES == WIDTH) begin : g_full
        assign shl_s = ser_in;
        assign shr_s = ser_in;
    end else begin : g_part
        assign shl_s = {sreg_q[WIDTH-LANES-1:0], ser_in};
        assign shr_s = {ser_in, sreg_q[WIDTH-1:LANES]};
    end

    shift_beat_counter #(
        .N (NB)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .count (beat_cnt_s),
        .last  (cnt_last_s)
    );

    // FSM and datapath next-state; abort outranks shift_en and cap_ready.
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        msb_first_d = msb_first_q;
        cnt_clr_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d     = SHIFT;
                    sreg_d      = load_data;
                    msb_first_d = load_msb_first;
                    cnt_clr_s   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d   = IDLE;
                    sreg_d    = '0;
                    cnt_clr_s = 1'b1;
                end else if (shift_en) begin
                    sreg_d = msb_first_q ? shl_s : shr_s;
                    if (cnt_last_s) begin
                        state_d   = HOLD;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = (beat_cnt_s < CW'(NB - 1));
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d   = IDLE;
                    sreg_d    = '0;
                    cnt_clr_s = 1'b1;
                end else if (cap_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d   = IDLE;
                sreg_d    = '0;
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // State, shift register and bit-order latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            msb_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            msb_first_q <= msb_first_d;
        end
    end

    // Serial output lanes are only live while shifting.
    always_comb begin
        ser_out = '0;
        if (state_q == SHIFT) begin
            ser_out = msb_first_q ? sreg_q[WIDTH-1 -: LANES] : sreg_q[LANES-1:0];
        end else begin
            ser_out = '0;
        end
    end

    assign load_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign cap_valid  = (state_q == HOLD);
    assign cap_data   = (state_q == HOLD) ? sreg_q : '0;

endmodule
